draw_polygon_n: RTL and testbench

Parametrised polygon/polyline rasteriser for up to `MAXV` vertices. It walks the segments of an N-vertex outline, either closed or open, and feeds each segment to a `draw_line` instance, streaming one pixel coordinate per enabled cycle. It sits between the scene/vertex logic and the framebuffer write path, and supersedes the fixed quadrilateral drawer. Vertices are latched at start, so the caller may change inputs during drawing.

---
 rtl/draw_pkg.sv | 15 +
 rtl/draw_line.sv | 90 +++++++++
 rtl/draw_polygon_n.sv | 145 ++++++++++++++
 tb/tb_draw_polygon_n.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types for the polygon rasteriser: FSM state encoding and vertex-index width.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    FIN
  } state_t;

  function automatic int vidx_w(input int maxv);
    return $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/draw_line.sv
// Bresenham line drawer: one pixel per enabled cycle from (x0,y0) to (x1,y1) inclusive,
// in the direction given, with a one-cycle done pulse after the final pixel.
module draw_line #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  // error term needs headroom for |dx|+|dy| doubled
  localparam int EW = CORDW + 3;

  typedef enum logic [0:0] {L_IDLE, L_DRAW} lstate_t;

  lstate_t                 state;
  logic signed [CORDW-1:0] xe, ye;
  logic signed [EW-1:0]    dx, dy, err, e2, dx_in, dy_in;
  logic                    right, down, movx, movy;

  always_comb begin
    dx_in   = (x1 >= x0) ? EW'(x1) - EW'(x0) : EW'(x0) - EW'(x1);
    dy_in   = (y1 >= y0) ? EW'(y0) - EW'(y1) : EW'(y1) - EW'(y0);
    e2      = err <<< 1;
    movx    = (e2 >= dy);
    movy    = (e2 <= dx);
    drawing = (state == L_DRAW) && oe;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= L_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      y     <= '0;
      xe    <= '0;
      ye    <= '0;
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
      right <= 1'b0;
      down  <= 1'b0;
    end else begin
      case (state)
        L_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= L_DRAW;
            busy  <= 1'b1;
            x     <= x0;
            y     <= y0;
            xe    <= x1;
            ye    <= y1;
            right <= (x1 >= x0);
            down  <= (y1 >= y0);
            dx    <= dx_in;
            dy    <= dy_in;
            err   <= dx_in + dy_in;
          end
        end
        L_DRAW: begin
          if (oe) begin
            if (x == xe && y == ye) begin
              state <= L_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              if (movx) x <= right ? x + CORDW'(1) : x - CORDW'(1);
              if (movy) y <= down ? y + CORDW'(1) : y - CORDW'(1);
              err <= err + (movx ? dy : '0) + (movy ? dx : '0);
            end
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/draw_polygon_n.sv
// Polygon/polyline rasteriser: latches up to MAXV vertices on start and walks
// each outline segment through draw_line, streaming one pixel per enabled cycle.
//
// state | meaning
// IDLE  | waiting for start; vertices latched and segment count computed on start
// SETUP | endpoints v[seg], v[seg+1 wrapped] loaded into the line registers
// DRAW  | line drawer running; advance segment or finish on its done pulse
// FIN   | drop busy, raise the one-cycle done pulse
module draw_polygon_n
  import draw_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int MAXV  = 8,
  parameter int VW    = vidx_w(MAXV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic [VW-1:0]           nverts,
  input  logic                    closed,
  input  logic [MAXV*CORDW-1:0]   xs,
  input  logic [MAXV*CORDW-1:0]   ys,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(MAXV);

  state_t                  state, state_n;
  logic [VW-1:0]           seg, seg_n, n_q, s_q, n_clamp, s_calc, nxt;
  logic                    busy_n, done_n, line_start, line_start_n;
  logic                    load_v, load_ep, line_done;
  logic signed [CORDW-1:0] vx [MAXV];
  logic signed [CORDW-1:0] vy [MAXV];
  logic signed [CORDW-1:0] ax, ay, bx, by;

  always_comb begin
    n_clamp = (nverts > VW'(MAXV)) ? VW'(MAXV) : nverts;
    // a two-vertex closed outline gets a single segment, not a doubled one
    if (n_clamp < VW'(2))
      s_calc = '0;
    else if (closed && n_clamp >= VW'(3))
      s_calc = n_clamp;
    else
      s_calc = n_clamp - VW'(1);
    nxt = (seg == n_q - VW'(1)) ? '0 : seg + VW'(1);
  end

  always_comb begin
    state_n      = state;
    seg_n        = seg;
    busy_n       = busy;
    done_n       = done;
    line_start_n = line_start;
    load_v       = 1'b0;
    load_ep      = 1'b0;
    case (state)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          load_v  = 1'b1;
          seg_n   = '0;
          busy_n  = 1'b1;
          state_n = (s_calc != '0) ? SETUP : FIN;
        end
      end
      SETUP: begin
        load_ep      = 1'b1;
        line_start_n = 1'b1;
        state_n      = DRAW;
      end
      DRAW: begin
        line_start_n = 1'b0;
        if (line_done) begin
          if (seg == s_q - VW'(1)) begin
            state_n = FIN;
          end else begin
            seg_n   = seg + VW'(1);
            state_n = SETUP;
          end
        end
      end
      FIN: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      seg        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      line_start <= 1'b0;
    end else begin
      state      <= state_n;
      seg        <= seg_n;
      busy       <= busy_n;
      done       <= done_n;
      line_start <= line_start_n;
    end
  end

  always_ff @(posedge clk) begin
    if (load_v) begin
      n_q <= n_clamp;
      s_q <= s_calc;
      for (int i = 0; i < MAXV; i++) begin
        vx[i] <= xs[i*CORDW +: CORDW];
        vy[i] <= ys[i*CORDW +: CORDW];
      end
    end
    if (load_ep) begin
      ax <= vx[seg[IW-1:0]];
      ay <= vy[seg[IW-1:0]];
      bx <= vx[nxt[IW-1:0]];
      by <= vy[nxt[IW-1:0]];
    end
  end

  draw_line #(.CORDW(CORDW)) u_line (
    .clk     (clk),
    .rst     (rst),
    .start   (line_start),
    .oe      (oe),
    .x0      (ax),
    .y0      (ay),
    .x1      (bx),
    .y1      (by),
    .x       (x),
    .y       (y),
    .drawing (drawing),
    .busy    (),
    .done    (line_done)
  );

endmodule

// File: tb/tb_draw_polygon_n.sv
// Directed bench for draw_polygon_n: outlines with hand-derived pixel counts and endpoints.
module tb_draw_polygon_n;

  localparam int CORDW = 16;
  localparam int MAXV  = 8;
  localparam int VW    = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    oe = 1'b1;
  logic                    closed = 1'b0;
  logic [VW-1:0]           nverts = '0;
  logic [MAXV*CORDW-1:0]   xs = '0;
  logic [MAXV*CORDW-1:0]   ys = '0;
  logic signed [CORDW-1:0] x, y;
  logic                    drawing, busy, done;

  int passed = 0;
  int total  = 0;

  logic signed [CORDW-1:0] cap_x[$];
  logic signed [CORDW-1:0] cap_y[$];
  int cap_done_n, cap_done_cyc;
  bit cap_busy1, cap_busy_at_done, cap_timeout;

  draw_polygon_n #(.CORDW(CORDW), .MAXV(MAXV)) dut (
    .clk(clk), .rst(rst), .start(start), .oe(oe), .nverts(nverts), .closed(closed),
    .xs(xs), .ys(ys), .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_v();
    xs = '0;
    ys = '0;
  endtask

  task automatic set_v(input int i, input int vx, input int vy);
    xs[i*CORDW +: CORDW] = CORDW'(vx);
    ys[i*CORDW +: CORDW] = CORDW'(vy);
  endtask

  task automatic set_square();
    clear_v();
    set_v(0, 0, 0); set_v(1, 7, 0); set_v(2, 7, 7); set_v(3, 0, 7);
    nverts = 4'd4;
    closed = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Records pixels and done pulses from cycle 1 (first negedge after start is sampled).
  // At mid_cyc the vertices are scrambled and start is pulsed for one cycle.
  task automatic capture(input int mid_cyc, input bit rand_oe);
    int  cyc;
    bit  seen;
    cap_x.delete(); cap_y.delete();
    cap_done_n = 0; cap_done_cyc = -1; cap_busy1 = 1'b0; cap_busy_at_done = 1'b1;
    cap_timeout = 1'b1; seen = 1'b0; cyc = 1;
    for (int k = 0; k < 3000; k++) begin
      if (rand_oe) oe = 1'($urandom_range(0, 1));
      if (cyc == mid_cyc) begin
        for (int i = 0; i < MAXV; i++) set_v(i, 100 + i, -50);
        nverts = 4'd2;
        closed = 1'b0;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc == 1) cap_busy1 = busy;
      if (drawing) begin
        cap_x.push_back(x);
        cap_y.push_back(y);
      end
      if (done) begin
        cap_done_n++;
        if (!seen) begin
          cap_done_cyc = cyc;
          cap_busy_at_done = busy;
        end
        seen = 1'b1;
      end
      if (seen && cyc >= cap_done_cyc + 4) begin
        cap_timeout = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    oe = 1'b1;
    start = 1'b0;
  endtask

  function automatic int square_mismatches();
    int n, ex, ey, k;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      k = i % 8;
      case (i / 8)
        0:       begin ex = k;     ey = 0;     end
        1:       begin ex = 7;     ey = k;     end
        2:       begin ex = 7 - k; ey = 7;     end
        default: begin ex = 0;     ey = 7 - k; end
      endcase
      if (i >= cap_x.size()) n++;
      else if (int'(cap_x[i]) != ex || int'(cap_y[i]) != ey) n++;
    end
    return n;
  endfunction

  function automatic int last_x();
    return (cap_x.size() > 0) ? int'(cap_x[cap_x.size()-1]) : 99999;
  endfunction

  function automatic int last_y();
    return (cap_y.size() > 0) ? int'(cap_y[cap_y.size()-1]) : 99999;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (drawing !== 1'b0) $display("FAIL reset_drawing: got %b expected 0", drawing); else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_square();
    int mm;
    set_square();
    pulse_start();
    capture(-1, 1'b0);
    mm = square_mismatches();
    total++; if (cap_timeout) $display("FAIL sq_timeout: no done within bound"); else passed++;
    total++; if (cap_x.size() != 32) $display("FAIL sq_count: got %0d expected 32", cap_x.size()); else passed++;
    total++; if (mm != 0) $display("FAIL sq_sequence: got %0d bad pixels expected 0", mm); else passed++;
    total++; if (last_x() != 0 || last_y() != 0)
      $display("FAIL sq_last: got (%0d,%0d) expected (0,0)", last_x(), last_y()); else passed++;
    total++; if (cap_done_n != 1) $display("FAIL sq_done_count: got %0d expected 1", cap_done_n); else passed++;
    total++; if (cap_busy_at_done !== 1'b0) $display("FAIL sq_busy_at_done: got %b expected 0", cap_busy_at_done); else passed++;
    total++; if (cap_busy1 !== 1'b1) $display("FAIL sq_busy_cycle1: got %b expected 1", cap_busy1); else passed++;
  endtask

  task automatic test_open_polyline();
    clear_v();
    set_v(0, 0, 0); set_v(1, 4, 0); set_v(2, 4, 4);
    nverts = 4'd3;
    closed = 1'b0;
    pulse_start();
    capture(-1, 1'b0);
    total++; if (cap_x.size() != 10) $display("FAIL open_count: got %0d expected 10", cap_x.size()); else passed++;
    total++; if (last_x() != 4 || last_y() != 4)
      $display("FAIL open_last: got (%0d,%0d) expected (4,4)", last_x(), last_y()); else passed++;
    total++; if (cap_done_n != 1) $display("FAIL open_done_count: got %0d expected 1", cap_done_n); else passed++;
  endtask

  task automatic test_two_vertex_signed();
    clear_v();
    set_v(0, -3, -3); set_v(1, 2, -3);
    nverts = 4'd2;
    closed = 1'b1;
    pulse_start();
    capture(-1, 1'b0);
    total++; if (cap_x.size() != 6) $display("FAIL n2_count: got %0d expected 6", cap_x.size()); else passed++;
    total++; if (cap_x.size() == 0 || int'(cap_x[0]) != -3 || int'(cap_y[0]) != -3)
      $display("FAIL n2_first: got size %0d expected first pixel (-3,-3)", cap_x.size()); else passed++;
    total++; if (last_x() != 2 || last_y() != -3)
      $display("FAIL n2_last: got (%0d,%0d) expected (2,-3)", last_x(), last_y()); else passed++;
  endtask

  task automatic test_degenerate();
    for (int n = 0; n < 2; n++) begin
      clear_v();
      set_v(0, 5, 5);
      nverts = VW'(n);
      closed = 1'b1;
      pulse_start();
      capture(-1, 1'b0);
      total++; if (cap_done_cyc != 2) $display("FAIL n%0d_done_cycle: got %0d expected 2", n, cap_done_cyc); else passed++;
      total++; if (cap_x.size() != 0) $display("FAIL n%0d_pixels: got %0d expected 0", n, cap_x.size()); else passed++;
      total++; if (cap_busy1 !== 1'b1) $display("FAIL n%0d_busy: got %b expected 1", n, cap_busy1); else passed++;
    end
  endtask

  task automatic test_clamp();
    clear_v();
    set_v(0, 0, 0); set_v(1, 2, 0); set_v(2, 4, 0); set_v(3, 4, 2);
    set_v(4, 4, 4); set_v(5, 2, 4); set_v(6, 0, 4); set_v(7, 0, 2);
    nverts = 4'd15;
    closed = 1'b1;
    pulse_start();
    capture(-1, 1'b0);
    total++; if (cap_x.size() != 24) $display("FAIL clamp_count: got %0d expected 24", cap_x.size()); else passed++;
    total++; if (last_x() != 0 || last_y() != 0)
      $display("FAIL clamp_last: got (%0d,%0d) expected (0,0)", last_x(), last_y()); else passed++;
  endtask

  task automatic test_latch_and_ignore();
    int mm;
    set_square();
    pulse_start();
    capture(6, 1'b0);
    mm = square_mismatches();
    total++; if (cap_x.size() != 32 || mm != 0)
      $display("FAIL latch_sequence: got %0d pixels %0d bad expected 32 pixels 0 bad", cap_x.size(), mm); else passed++;
    total++; if (cap_done_n != 1) $display("FAIL latch_done_count: got %0d expected 1", cap_done_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ignored_start_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_oe_stall();
    int mm;
    set_square();
    pulse_start();
    capture(-1, 1'b1);
    mm = square_mismatches();
    total++; if (cap_x.size() != 32 || mm != 0)
      $display("FAIL oe_sequence: got %0d pixels %0d bad expected 32 pixels 0 bad", cap_x.size(), mm); else passed++;
    total++; if (cap_done_n != 1) $display("FAIL oe_done_count: got %0d expected 1", cap_done_n); else passed++;
  endtask

  task automatic test_mid_reset();
    int dones, busys;
    set_square();
    pulse_start();
    repeat (6) @(negedge clk);
    #1;
    total++; if (drawing !== 1'b1) $display("FAIL mrst_pre_drawing: got %b expected 1", drawing); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0 || drawing !== 1'b0 || done !== 1'b0)
      $display("FAIL mrst_outputs: got busy=%b drawing=%b done=%b expected all 0", busy, drawing, done); else passed++;
    @(negedge clk);
    rst = 1'b1;
    dones = 0; busys = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done) dones++;
      if (busy || drawing) busys++;
    end
    total++; if (dones != 0 || busys != 0)
      $display("FAIL mrst_after: got %0d done and %0d active cycles expected 0 and 0", dones, busys); else passed++;
  endtask

  task automatic test_back_to_back();
    bit found;
    clear_v();
    nverts = 4'd1;
    closed = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!found) $display("FAIL b2b_first_done: got none expected done within 10 cycles"); else passed++;
    clear_v();
    set_v(0, 0, 0); set_v(1, 3, 0);
    nverts = 4'd2;
    closed = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy); else passed++;
    capture(-1, 1'b0);
    total++; if (cap_x.size() != 4 || last_x() != 3 || last_y() != 0)
      $display("FAIL b2b_pixels: got %0d ending (%0d,%0d) expected 4 ending (3,0)", cap_x.size(), last_x(), last_y());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_square();
    test_open_polyline();
    test_two_vertex_signed();
    test_degenerate();
    test_clamp();
    test_latch_and_ignore();
    test_oe_stall();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
